// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin slot arbiters.
package arb_pkg;

    // Controller sequencing: idle, a resource owner, one dead cycle between owners.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OWN     = 2'd1,
        RELEASE = 2'd2
    } arb_state_type;

    // Index width for a requester count; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int N_REQ_DEFAULT  = 3;
    localparam int IDX_W_DEFAULT  = idx_w(N_REQ_DEFAULT);
    localparam int SLOT_W_DEFAULT = 4;

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority picker: first set request scanning ptr, ptr+1, ... mod N_REQ.
// Purely combinational so it can be dropped into other arbiters.
module rr_pick #(
    parameter int N_REQ = 3,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    // Scan from the farthest offset down so the nearest set bit to ptr wins last.
    always_comb begin
        int c;
        c     = 0;
        valid = 1'b0;
        idx   = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            c = (int'(ptr) + i) % N_REQ;
            if (req[c]) begin
                valid = 1'b1;
                idx   = IDX_W'(c);
            end
        end
    end

endmodule

// File: rtl/rr_slot_arbiter.sv
// Time-slot round-robin arbiter: one owner at a time for up to slot_len cycles,
// priority rotates past each winner, one dead cycle separates owners.
//
// Handshake: req[i] is a level request held until grant[i] rises; grant is the
// acknowledge and stays high for the slot. The owner ends its slot early by
// pulsing done[i] or by dropping req[i]; grant falls on the following edge.
module rr_slot_arbiter
    import arb_pkg::*;
#(
    parameter int N_REQ  = 3,
    parameter int SLOT_W = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ-1:0]         done,
    input  logic [SLOT_W-1:0]        slot_len,
    output logic [N_REQ-1:0]         grant,
    output logic [$clog2(N_REQ)-1:0] owner,
    output logic                     busy,
    output arb_state_type            state_dbg
);

    localparam int IDX_W = $clog2(N_REQ);

    arb_state_type     state;
    arb_state_type     state_next;
    logic [IDX_W-1:0]  ptr;
    logic [SLOT_W-1:0] cnt;

    logic              pick_valid;
    logic [IDX_W-1:0]  pick_idx;
    logic [IDX_W-1:0]  ptr_after_win;
    logic [SLOT_W-1:0] cnt_load;
    logic [N_REQ-1:0]  win_onehot;
    logic              leave_own;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req   (req),
        .ptr   (ptr),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    assign state_dbg = state;

    // Arbitration side values: rotated pointer, slot load (0 behaves as 1), one-hot winner.
    always_comb begin
        ptr_after_win = (pick_idx == IDX_W'(N_REQ - 1)) ? '0 : pick_idx + IDX_W'(1);
        cnt_load      = (slot_len == '0) ? '0 : slot_len - SLOT_W'(1);
        win_onehot    = N_REQ'(1) << pick_idx;
        leave_own     = done[owner] | ~req[owner] | (cnt == '0);
    end

    // Next-state decision; RELEASE arbitrates exactly like IDLE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = pick_valid ? OWN : IDLE;
            OWN:     state_next = leave_own ? RELEASE : OWN;
            RELEASE: state_next = pick_valid ? OWN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State, registered outputs, priority pointer and slot counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            grant <= '0;
            owner <= '0;
            busy  <= 1'b0;
            ptr   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE, RELEASE: begin
                    if (pick_valid) begin
                        owner <= pick_idx;
                        grant <= win_onehot;
                        busy  <= 1'b1;
                        ptr   <= ptr_after_win;
                        cnt   <= cnt_load;
                    end else begin
                        grant <= '0;
                        busy  <= 1'b0;
                    end
                end
                OWN: begin
                    if (leave_own) begin
                        grant <= '0;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt - SLOT_W'(1);
                    end
                end
                default: begin
                    grant <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_slot_arbiter.sv
// Bench for rr_slot_arbiter: directed vector table, a hand-written mid-slot
// reset sequence, and randomized traffic against a slot-level reference model.
module tb_rr_slot_arbiter;
    import arb_pkg::*;

    localparam int N = 3;
    localparam int SW = 4;

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [N-1:0]  req = '0;
    logic [N-1:0]  done = '0;
    logic [SW-1:0] slot_len = '0;
    logic [N-1:0]  grant;
    logic [1:0]    owner;
    logic          busy;
    arb_state_type state_dbg;

    always #5 clk = ~clk;

    rr_slot_arbiter #(.N_REQ(N), .SLOT_W(SW)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .done      (done),
        .slot_len  (slot_len),
        .grant     (grant),
        .owner     (owner),
        .busy      (busy),
        .state_dbg (state_dbg)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit            rst;
        logic [N-1:0]  req;
        logic [N-1:0]  done;
        logic [SW-1:0] sl;
        logic [N-1:0]  eg;
        int            eo;
        bit            eb;
        string         tag;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input bit rst, input logic [N-1:0] r, input logic [N-1:0] d,
                                input logic [SW-1:0] sl, input logic [N-1:0] eg,
                                input int eo, input string tag);
        vec_t v;
        v.rst = rst; v.req = r; v.done = d; v.sl = sl;
        v.eg = eg; v.eo = eo; v.eb = (eg != '0); v.tag = tag;
        vecs.push_back(v);
    endfunction

    // ---------------- reference model ----------------
    // Slot-level view: either someone holds the resource with some cycles left,
    // or nobody does and the next edge arbitrates.
    int m_own, m_left, m_owner, m_ptr;

    task automatic model_reset();
        m_own = -1; m_left = 0; m_owner = 0; m_ptr = 0;
    endtask

    task automatic model_step(input logic [N-1:0] r, input logic [N-1:0] d, input logic [SW-1:0] sl);
        if (m_own >= 0) begin
            if (d[m_own] || !r[m_own] || m_left == 1) m_own = -1;
            else m_left--;
        end else begin
            for (int k = 0; k < N; k++) begin
                int c;
                c = (m_ptr + k) % N;
                if (r[c]) begin
                    m_own = c; m_owner = c; m_ptr = (c + 1) % N;
                    m_left = (sl == 0) ? 1 : int'(sl);
                    break;
                end
            end
        end
    endtask

    logic [5:0] exp_q[$];

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        reset = 1'b1;
        req = '0; done = '0;
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic run_table();
        foreach (vecs[i]) begin
            req = vecs[i].req; done = vecs[i].done; slot_len = vecs[i].sl;
            if (vecs[i].rst) reset = 1'b1;
            @(posedge clk); #1;
            check({vecs[i].tag, "_grant"}, int'(grant), int'(vecs[i].eg));
            check({vecs[i].tag, "_owner"}, int'(owner), vecs[i].eo);
            check({vecs[i].tag, "_busy"},  int'(busy),  int'(vecs[i].eb));
            if (vecs[i].rst) begin
                check({vecs[i].tag, "_state"}, int'(state_dbg), int'(IDLE));
                reset = 1'b0;
            end
            done = '0;
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        // reset with all requesting, then rotation with slot_len=1
        add(1, 3'b111, 3'b000, 4'd1, 3'b000, 0, "rst");
        add(0, 3'b111, 3'b000, 4'd1, 3'b001, 0, "rot0");
        add(0, 3'b111, 3'b000, 4'd1, 3'b000, 0, "rot1");
        add(0, 3'b111, 3'b000, 4'd1, 3'b010, 1, "rot2");
        add(0, 3'b111, 3'b000, 4'd1, 3'b000, 1, "rot3");
        add(0, 3'b111, 3'b000, 4'd1, 3'b100, 2, "rot4");
        add(0, 3'b111, 3'b000, 4'd1, 3'b000, 2, "rot5");
        add(0, 3'b111, 3'b000, 4'd1, 3'b001, 0, "rot6");
        // full slot of 4 for requester 1
        add(1, 3'b000, 3'b000, 4'd4, 3'b000, 0, "rst_full");
        for (int i = 0; i < 4; i++) add(0, 3'b010, 3'b000, 4'd4, 3'b010, 1, "full_on");
        add(0, 3'b010, 3'b000, 4'd4, 3'b000, 1, "full_gap");
        add(0, 3'b010, 3'b000, 4'd4, 3'b010, 1, "full_again");
        // early release in 2nd grant cycle, then foreign done ignored
        add(1, 3'b000, 3'b000, 4'd8, 3'b000, 0, "rst_early");
        add(0, 3'b001, 3'b000, 4'd8, 3'b001, 0, "early_c1");
        add(0, 3'b001, 3'b000, 4'd8, 3'b001, 0, "early_c2");
        add(0, 3'b001, 3'b001, 4'd8, 3'b000, 0, "early_fall");
        add(0, 3'b001, 3'b000, 4'd8, 3'b001, 0, "early_regrant");
        add(0, 3'b001, 3'b100, 4'd8, 3'b001, 0, "foreign_done");
        add(0, 3'b001, 3'b000, 4'd8, 3'b001, 0, "foreign_after");
        // slot_len=0 behaves as 1
        add(1, 3'b000, 3'b000, 4'd0, 3'b000, 0, "rst_zero");
        add(0, 3'b010, 3'b000, 4'd0, 3'b010, 1, "zero_on");
        add(0, 3'b010, 3'b000, 4'd0, 3'b000, 1, "zero_off");
        add(0, 3'b010, 3'b000, 4'd0, 3'b010, 1, "zero_on2");
        add(0, 3'b010, 3'b000, 4'd0, 3'b000, 1, "zero_off2");
        // pointer wrap after R2 wins
        add(1, 3'b000, 3'b000, 4'd1, 3'b000, 0, "rst_wrap");
        add(0, 3'b100, 3'b000, 4'd1, 3'b100, 2, "wrap_r2");
        add(0, 3'b011, 3'b000, 4'd1, 3'b000, 2, "wrap_gap");
        add(0, 3'b011, 3'b000, 4'd1, 3'b001, 0, "wrap_r0");
        add(0, 3'b011, 3'b000, 4'd1, 3'b000, 0, "wrap_gap2");
        add(0, 3'b011, 3'b000, 4'd1, 3'b010, 1, "wrap_r1");

        run_table();

        // mid-slot asynchronous reset during a 6-cycle R1 slot
        do_reset();
        req = 3'b010; slot_len = 4'd6;
        @(posedge clk); #1;
        check("mid_c1_grant", int'(grant), 2);
        @(posedge clk); #1;
        @(posedge clk); #2;
        check("mid_c3_grant", int'(grant), 2);
        reset = 1'b1; #1;
        check("mid_rst_grant", int'(grant), 0);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_owner", int'(owner), 0);
        @(negedge clk);
        reset = 1'b0;
        req = 3'b110;
        @(posedge clk); #1;
        check("mid_after_grant", int'(grant), 2);
        check("mid_after_owner", int'(owner), 1);

        // randomized traffic against the reference model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) req = N'($urandom_range(0, 7));
            done = ($urandom_range(0, 7) == 0) ? N'(1 << $urandom_range(0, 2)) : '0;
            if ($urandom_range(0, 15) == 0) slot_len = SW'($urandom_range(0, 6));
            @(posedge clk);
            model_step(req, done, slot_len);
            exp_q.push_back({(m_own >= 0) ? N'(1 << m_own) : N'(0), 2'(m_owner), m_own >= 0});
            #1;
            begin
                logic [5:0] e;
                e = exp_q.pop_front();
                n_tests++;
                if ({grant, owner, busy} != e) begin
                    n_fail++;
                    $display("FAIL rand[%0d]: grant/owner/busy got %b/%0d/%b expected %b/%0d/%b",
                             i, grant, owner, busy, e[5:3], e[2:1], e[0]);
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
